mem_bus_arbiter: RTL

- Two-master, one-slave round-robin arbiter for the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets the CPU core (m0) and a secondary requester such as a DMA or firmware loader (m1) share the single RAM/UART memory controller (s).
- Adds a per-transaction timeout so that a slave that never responds cannot hang the bus.

---
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus, with a per-transaction timeout.
// Latency: one arbitration cycle from request to s_valid; completion is combinational from s_ready.
// Backpressure: the owner holds the bus until s_ready or timeout; IDLE always separates transactions.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide so it still elaborates.
  localparam bit          TO_EN   = (TIMEOUT > 0);
  localparam int          CW      = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          own_sel;
  logic          own_valid;
  logic          timeout_hit;
  logic          own_ready;
  logic [31:0]   own_rdata;

  // State, round-robin pointer and timeout counter; last_grant resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state and all bus outputs; outputs are zero in IDLE so reset forces them low asynchronously.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    own_sel      = 1'b0;
    own_valid    = 1'b0;
    timeout_hit  = 1'b0;
    own_ready    = 1'b0;
    own_rdata    = '0;
    s_valid      = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wstrb      = '0;
    grant        = 2'b00;
    timeout_err  = 1'b0;
    m0_ready     = 1'b0;
    m0_rdata     = '0;
    m1_ready     = 1'b0;
    m1_rdata     = '0;

    case (state_q)
      IDLE: begin
        // Tie goes to whichever master did not own the bus last.
        if (m0_valid && (!m1_valid || last_grant_q)) begin
          state_d      = OWN0;
          last_grant_d = 1'b0;
          cnt_d        = '0;
        end else if (m1_valid) begin
          state_d      = OWN1;
          last_grant_d = 1'b1;
          cnt_d        = '0;
        end
      end

      OWN0, OWN1: begin
        own_sel     = (state_q == OWN1);
        own_valid   = own_sel ? m1_valid : m0_valid;
        s_addr      = own_sel ? m1_addr  : m0_addr;
        s_wdata     = own_sel ? m1_wdata : m0_wdata;
        s_wstrb     = own_sel ? m1_wstrb : m0_wstrb;
        grant       = own_sel ? 2'b10 : 2'b01;
        timeout_hit = TO_EN && (cnt_q == TO_LAST) && !s_ready;

        if (!own_valid) begin
          // Master withdrew its request: release the bus silently.
          state_d = IDLE;
        end else if (s_ready) begin
          // s_ready beats a coincident timeout.
          s_valid   = 1'b1;
          own_ready = 1'b1;
          own_rdata = s_rdata;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          own_ready   = 1'b1;
          own_rdata   = ERR_RDATA;
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          s_valid = 1'b1;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        if (own_sel) begin
          m1_ready = own_ready;
          m1_rdata = own_rdata;
        end else begin
          m0_ready = own_ready;
          m0_rdata = own_rdata;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
